uart_cmd_rx: RTL and testbench
==============================

# uart_cmd_rx

Receive-side command parser for the UART link. Consumes bytes from the UART receiver (`rx_byte`/`received`) and decodes ASCII register-write lines of the same format the transmit path emits, `R<n>:<hex digits><CR|LF>`. It presents each decoded command as a one-cycle strobe with register index and data word. It sits between the UART core and the sequencer register file, giving the host a write path into the design.

## Interface
- `DP_WIDTH`, 16, data word width in bits; must equal `4*NUM_NIB`.
- `NUM_NIB`, 4, exact number of hex digits per command.
- `TIMEOUT_CYC`, 0, inter-byte timeout in clk cycles while a command is in progress; 0 disables it.

Ports:
- `clk`, in, 1, clock.
- `rst`, in, 1, synchronous, active-high reset.
- `i_rx_data`, in, 8, received byte; valid only when `i_rx_valid` is high.
- `i_rx_valid`, in, 1, one-cycle strobe per received byte.
- `o_cmd_valid`, out, 1, one-cycle strobe: a complete, well-formed command was decoded.
- `o_cmd_reg`, out, 2, register index of the last good command.
- `o_cmd_data`, out, DP_WIDTH, data word of the last good command, first digit in the MSBs.
- `o_cmd_err`, out, 1, one-cycle strobe: the current command was aborted (bad byte or timeout).
- `o_busy`, out, 1, high while a command is partially received (state != stIdle).

## Operation
- States:
  - stIdle: wait for `'R'`.
  - stReg: expect a register digit.
  - stColon: expect `':'`.
  - stHex: collect hex digits; a nibble counter runs 0..NUM_NIB-1.
  - stTerm: expect a terminator.
- State transitions occur only on `i_rx_valid` cycles, except the timeout.
- stIdle:
  - `'R'` (0x52) -> stReg.
  - Every other byte, including stray CR/LF, is ignored silently with no error.
- stReg:
  - `'0'`..`'3'` -> latch the index into an internal reg, then -> stColon.
  - Any other byte -> error.
- stColon:
  - `':'` -> clear the shift register and nibble counter, then -> stHex.
  - Any other byte -> error.
- stHex:
  - Accept `'0'-'9'`, `'A'-'F'` and `'a'-'f'`.
  - Each digit shifts in as `shift <= {shift[DP_WIDTH-5:0], nib}` and increments the counter.
  - After the NUM_NIB-th digit -> stTerm.
  - A non-hex byte (including an early CR/LF) -> error.
- stTerm:
  - CR (0x0D) or LF (0x0A) -> load `o_cmd_reg`/`o_cmd_data` from the internal regs, pulse `o_cmd_valid`, then -> stIdle.
  - Any other byte -> error.
  - The transmitter sends `"\n\r"`. The second terminator arrives in stIdle and is ignored.
- Error:
  - Pulse `o_cmd_err`. `o_cmd_reg`/`o_cmd_data` are unchanged.
  - If the offending byte is `'R'`, go to stReg (resync). Otherwise go to stIdle.
- Timeout, when TIMEOUT_CYC > 0:
  - A counter clears on every `i_rx_valid` and on entry to stIdle, and increments every cycle while not in stIdle.
  - Reaching TIMEOUT_CYC -> pulse `o_cmd_err` and go to stIdle.
  - If a byte arrives in that same cycle, the byte wins and the counter clears.
  - The counter saturates, and is wide enough for TIMEOUT_CYC.

## Timing
- Reset values:
  - State stIdle.
  - `o_cmd_valid`=0, `o_cmd_err`=0, `o_cmd_reg`=0, `o_cmd_data`=0, `o_busy`=0.
  - Internal shift register, nibble counter and timeout counter all 0.
- Reset mid-command discards the partial command with no strobe.
- Latency:
  - `o_cmd_valid` is registered and rises the cycle after the terminator's `i_rx_valid`.
  - `o_cmd_reg`/`o_cmd_data` update in that same cycle and hold until the next good command.
- `o_cmd_err` is registered, one cycle after the offending byte or the timeout expiry.
- `o_cmd_valid` and `o_cmd_err` are never high together, and each is high for exactly one cycle.
- `o_busy` is combinational from state. It goes high the cycle after `'R'` is accepted and low the cycle `o_cmd_valid` or `o_cmd_err` is asserted.
- Back-to-back `i_rx_valid` on consecutive cycles must be accepted with no loss. No backpressure exists.
- Minimum command length is NUM_NIB+4 bytes.

## Test plan
- Good command: bytes `"R2:1A3f\n\r"` with DP_WIDTH=16.
  - Expect one `o_cmd_valid` the cycle after `'\n'`, `o_cmd_reg`=2, `o_cmd_data`=16'h1A3F.
  - `'\r'` is ignored: no strobe, `o_busy` stays 0.
- Back-to-back: `"R0:FFFF\rR3:0001\r"` with `i_rx_valid` high every cycle.
  - Expect two `o_cmd_valid` pulses carrying (0, 16'hFFFF), then (3, 16'h0001).
- Malformed:
  - `"R4:..."` -> `o_cmd_err` after `'4'`.
  - `"R1:12G4\r"` -> `o_cmd_err` after `'G'`.
  - `"R1:12\r"` -> `o_cmd_err` after `'\r'`.
  - In every case `o_cmd_data`/`o_cmd_reg` retain their previous values.
- Resync: `"R1:1R2:BEEF\n"`.
  - Expect `o_cmd_err` on the second `'R'`, then `o_cmd_valid` with reg 2, data 16'hBEEF.
- Timeout: TIMEOUT_CYC=100, send `"R1:"` then idle.
  - Expect `o_cmd_err` ~100 cycles after `':'` and `o_busy`→0.
  - A byte arriving exactly at the expiry cycle suppresses the error.
- Reset: assert `rst` after `"R1:AB"`, then send `"CD\n"`.
  - Expect no strobes and all outputs 0.
  - A following `"R1:ABCD\n"` decodes to (1, 16'hABCD).

Source files
------------

// File: rtl/uart_cmd_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_rx
// Brief    : Receive-side ASCII command parser. Decodes register-write lines
//            of the form  R<n>:<hex digits><CR|LF>  arriving byte by byte
//            from the UART receiver and emits a one-cycle command strobe
//            carrying the register index and data word, or a one-cycle
//            error strobe when a line is malformed or stalls.
// Revision : 1.0  initial release
// ============================================================================
module uart_cmd_rx #(
    parameter int DP_WIDTH    = 16,  // data word width, 4 bits per hex digit
    parameter int NUM_NIB     = 4,   // exact hex digit count per command
    parameter int TIMEOUT_CYC = 0    // inter-byte timeout in cycles, 0 = off
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          i_rx_data,
    input  logic                i_rx_valid,
    output logic                o_cmd_valid,
    output logic [1:0]          o_cmd_reg,
    output logic [DP_WIDTH-1:0] o_cmd_data,
    output logic                o_cmd_err,
    output logic                o_busy
);

    // ------------------------------------------------------------------------
    // Character codes
    // ------------------------------------------------------------------------
    localparam logic [7:0] C_CH_R     = 8'h52;
    localparam logic [7:0] C_CH_COLON = 8'h3A;
    localparam logic [7:0] C_CH_CR    = 8'h0D;
    localparam logic [7:0] C_CH_LF    = 8'h0A;
    localparam logic [7:0] C_CH_0     = 8'h30;
    localparam logic [7:0] C_CH_3     = 8'h33;
    localparam logic [7:0] C_CH_9     = 8'h39;
    localparam logic [7:0] C_CH_UA    = 8'h41;
    localparam logic [7:0] C_CH_UF    = 8'h46;
    localparam logic [7:0] C_CH_LA    = 8'h61;
    localparam logic [7:0] C_CH_LF_HEX = 8'h66;

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_REG   = 3'd1;
    localparam logic [2:0] ST_COLON = 3'd2;
    localparam logic [2:0] ST_HEX   = 3'd3;
    localparam logic [2:0] ST_TERM  = 3'd4;

    // Digit counter sizing; the last digit index ends the hex field.
    localparam int              C_NIB_W    = (NUM_NIB > 1) ? $clog2(NUM_NIB) : 1;
    localparam logic [C_NIB_W-1:0] C_NIB_LAST = C_NIB_W'(NUM_NIB - 1);

    // Timeout counter must be able to hold TIMEOUT_CYC itself.
    localparam int C_TO_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    logic [2:0]          r_state;
    logic [1:0]          r_reg_idx;
    logic [DP_WIDTH-1:0] r_shift;
    logic [C_NIB_W-1:0]  r_nib_cnt;
    logic                r_cmd_valid;
    logic                r_cmd_err;
    logic [1:0]          r_cmd_reg;
    logic [DP_WIDTH-1:0] r_cmd_data;

    logic                w_is_hex;
    logic [3:0]          w_nib;
    logic                w_is_term;
    logic                w_bad;
    logic                w_to_expire;

    // Hex digit recognition and nibble value (upper and lower case letters).
    always_comb begin
        w_is_hex = 1'b0;
        w_nib    = 4'd0;
        if (i_rx_data >= C_CH_0 && i_rx_data <= C_CH_9) begin
            w_is_hex = 1'b1;
            w_nib    = i_rx_data[3:0];
        end else if ((i_rx_data >= C_CH_UA && i_rx_data <= C_CH_UF) ||
                     (i_rx_data >= C_CH_LA && i_rx_data <= C_CH_LF_HEX)) begin
            // 'A'/'a' have low nibble 1, so adding 9 maps them to 10.
            w_is_hex = 1'b1;
            w_nib    = i_rx_data[3:0] + 4'd9;
        end
    end

    assign w_is_term = (i_rx_data == C_CH_CR) || (i_rx_data == C_CH_LF);

    // Flag a received byte that does not fit the field expected in this state.
    always_comb begin
        w_bad = 1'b0;
        if (i_rx_valid) begin
            case (r_state)
                ST_REG:   w_bad = !(i_rx_data >= C_CH_0 && i_rx_data <= C_CH_3);
                ST_COLON: w_bad = (i_rx_data != C_CH_COLON);
                ST_HEX:   w_bad = !w_is_hex;
                ST_TERM:  w_bad = !w_is_term;
                default:  w_bad = 1'b0;  // idle silently ignores stray bytes
            endcase
        end
    end

    generate
        if (TIMEOUT_CYC > 0) begin : g_timeout
            localparam logic [C_TO_W-1:0] C_TO_LIMIT = C_TO_W'(TIMEOUT_CYC);
            logic [C_TO_W-1:0] r_to_cnt;

            // Count quiet cycles of a partial command; saturate at the limit.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_to_cnt <= '0;
                end else if (i_rx_valid || (r_state == ST_IDLE)) begin
                    r_to_cnt <= '0;
                end else if (r_to_cnt != C_TO_LIMIT) begin
                    r_to_cnt <= r_to_cnt + 1'b1;
                end
            end

            // A byte landing in the expiry cycle takes precedence.
            assign w_to_expire = (r_state != ST_IDLE) && !i_rx_valid &&
                                 (r_to_cnt == C_TO_LIMIT);
        end else begin : g_no_timeout
            assign w_to_expire = 1'b0;
        end
    endgenerate

    // Command parser: state, field capture and registered strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_reg_idx   <= 2'd0;
            r_shift     <= '0;
            r_nib_cnt   <= '0;
            r_cmd_valid <= 1'b0;
            r_cmd_err   <= 1'b0;
            r_cmd_reg   <= 2'd0;
            r_cmd_data  <= '0;
        end else begin
            r_cmd_valid <= 1'b0;
            r_cmd_err   <= 1'b0;
            if (w_bad) begin
                // An offending 'R' is treated as the start of a new line.
                r_cmd_err <= 1'b1;
                r_state   <= (i_rx_data == C_CH_R) ? ST_REG : ST_IDLE;
            end else if (i_rx_valid) begin
                case (r_state)
                    ST_IDLE: begin
                        if (i_rx_data == C_CH_R) begin
                            r_state <= ST_REG;
                        end
                    end
                    ST_REG: begin
                        r_reg_idx <= i_rx_data[1:0];
                        r_state   <= ST_COLON;
                    end
                    ST_COLON: begin
                        r_shift   <= '0;
                        r_nib_cnt <= '0;
                        r_state   <= ST_HEX;
                    end
                    ST_HEX: begin
                        // First digit ends up in the MSBs after NUM_NIB shifts.
                        r_shift   <= {r_shift[DP_WIDTH-5:0], w_nib};
                        r_nib_cnt <= r_nib_cnt + 1'b1;
                        if (r_nib_cnt == C_NIB_LAST) begin
                            r_state <= ST_TERM;
                        end
                    end
                    ST_TERM: begin
                        r_cmd_valid <= 1'b1;
                        r_cmd_reg   <= r_reg_idx;
                        r_cmd_data  <= r_shift;
                        r_state     <= ST_IDLE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end else if (w_to_expire) begin
                r_cmd_err <= 1'b1;
                r_state   <= ST_IDLE;
            end
        end
    end

    assign o_cmd_valid = r_cmd_valid;
    assign o_cmd_err   = r_cmd_err;
    assign o_cmd_reg   = r_cmd_reg;
    assign o_cmd_data  = r_cmd_data;
    assign o_busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_cmd_rx
// Brief    : Self-checking bench for uart_cmd_rx. Directed command lines plus
//            randomly generated (and occasionally corrupted) lines, compared
//            against a position-based line model.
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_cmd_rx;

    localparam int DW      = 16;
    localparam int NN      = 4;
    localparam int TO_CYC  = 100;

    localparam logic [7:0] CH_R  = 8'h52;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          cmd_valid;
    logic [1:0]    cmd_reg;
    logic [DW-1:0] cmd_data;
    logic          cmd_err;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    // Reference model state: bytes of the line in progress, last good command.
    logic [7:0]    q[$];
    logic [1:0]    m_reg;
    logic [DW-1:0] m_data;

    uart_cmd_rx #(
        .DP_WIDTH    (DW),
        .NUM_NIB     (NN),
        .TIMEOUT_CYC (TO_CYC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_rx_data   (rx_data),
        .i_rx_valid  (rx_valid),
        .o_cmd_valid (cmd_valid),
        .o_cmd_reg   (cmd_reg),
        .o_cmd_data  (cmd_data),
        .o_cmd_err   (cmd_err),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic bit is_hex(input logic [7:0] b);
        return (b >= "0" && b <= "9") || (b >= "A" && b <= "F") || (b >= "a" && b <= "f");
    endfunction

    function automatic int hexval(input logic [7:0] b);
        if (b >= "0" && b <= "9") return int'(b) - 48;
        if (b >= "A" && b <= "F") return int'(b) - 55;
        return int'(b) - 87;
    endfunction

    // Does byte b belong at character position pos of a well-formed line?
    function automatic bit fits(input int pos, input logic [7:0] b);
        if (pos == 1)       return (b >= "0" && b <= "3");
        if (pos == 2)       return (b == ":");
        if (pos < NN + 3)   return is_hex(b);
        return (b == CH_CR) || (b == CH_LF);
    endfunction

    task automatic model_byte(input logic [7:0] b, output logic ev, output logic ee);
        int pos;
        ev = 1'b0;
        ee = 1'b0;
        if (q.size() == 0) begin
            if (b == CH_R) q.push_back(b);
        end else begin
            pos = q.size();
            if (fits(pos, b)) begin
                q.push_back(b);
                if (pos == NN + 3) begin
                    ev     = 1'b1;
                    m_reg  = 2'(q[1] - 8'h30);
                    m_data = '0;
                    for (int i = 3; i < 3 + NN; i++)
                        m_data = (m_data << 4) | DW'(hexval(q[i]));
                    q.delete();
                end
            end else begin
                ee = 1'b1;
                q.delete();
                if (b == CH_R) q.push_back(b);
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic ev, input logic ee);
        check({tag, "_valid"}, 32'(cmd_valid), 32'(ev));
        check({tag, "_err"},   32'(cmd_err),   32'(ee));
        check({tag, "_busy"},  32'(busy),      32'(q.size() != 0));
        check({tag, "_reg"},   32'(cmd_reg),   32'(m_reg));
        check({tag, "_data"},  32'(cmd_data),  32'(m_data));
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic ev, ee;
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        model_byte(b, ev, ee);
        check_outputs($sformatf("byte_%02h", b), ev, ee);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check_outputs("idle", 1'b0, 1'b0);
        end
    endtask

    initial begin
        logic [7:0] line[$];
        int         nib;

        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        m_reg    = 2'd0;
        m_data   = '0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs("reset", 1'b0, 1'b0);
        rst = 1'b0;
        idle(2);

        // Good command, mixed-case hex, trailing second terminator ignored.
        send_str("R2:1A3f\n\r");
        check("good_reg_const",  32'(cmd_reg),  32'd2);
        check("good_data_const", 32'(cmd_data), 32'h1A3F);
        idle(2);

        // Two commands with a byte every cycle.
        send_str("R0:FFFF\rR3:0001\r");
        check("b2b_data_const", 32'(cmd_data), 32'h0001);
        idle(2);

        // Malformed lines: bad index, bad digit, early terminator.
        send_str("R4:");
        idle(1);
        send_str("R1:12G4\r");
        idle(1);
        send_str("R1:12\r");
        idle(1);

        // Resync on an 'R' in the middle of a line.
        send_str("R1:1R2:BEEF\n");
        check("resync_data_const", 32'(cmd_data), 32'hBEEF);
        idle(2);

        // Timeout: line stalls after ':'; error when the quiet count reaches the limit.
        send_str("R1:");
        for (int k = 1; k <= TO_CYC + 1; k++) begin
            @(posedge clk);
            #1;
            if (k <= TO_CYC) begin
                check_outputs("to_wait", 1'b0, 1'b0);
            end else begin
                q.delete();
                check_outputs("to_expire", 1'b0, 1'b1);
            end
        end
        idle(3);

        // A digit arriving exactly in the expiry cycle keeps the line alive.
        send_str("R1:");
        idle(TO_CYC);
        send_str("ABCD\n");
        check("to_save_data_const", 32'(cmd_data), 32'hABCD);
        idle(2);

        // Reset mid-command discards the partial line and clears outputs.
        send_str("R3:12");
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        m_reg  = 2'd0;
        m_data = '0;
        check_outputs("rst_mid", 1'b0, 1'b0);
        send_str("CD\n");
        idle(1);
        send_str("R1:ABCD\n");
        check("post_rst_reg_const", 32'(cmd_reg), 32'd1);
        idle(2);

        // Random lines, sometimes with a corrupted byte, random short gaps.
        for (int n = 0; n < 60; n++) begin
            line.delete();
            line.push_back(CH_R);
            line.push_back(8'h30 + 8'($urandom_range(0, 4)));
            line.push_back(":");
            for (int i = 0; i < NN; i++) begin
                nib = int'($urandom_range(0, 15));
                if (nib < 10)
                    line.push_back(8'(48 + nib));
                else
                    line.push_back(8'(($urandom_range(0, 1) != 0 ? 87 : 55) + nib));
            end
            line.push_back($urandom_range(0, 1) != 0 ? CH_LF : CH_CR);
            if ($urandom_range(0, 4) == 0)
                line[$urandom_range(0, line.size() - 1)] = 8'($urandom_range(0, 255));
            for (int i = 0; i < line.size(); i++) begin
                send_byte(line[i]);
                idle(int'($urandom_range(0, 1)));
            end
            idle(int'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
